keypad_matrix_scanner: RTL

Parametrised successor to the board's fixed button-array scanner. It scans a ROWS×COLS active-low key matrix and debounces every key independently. Press and release transitions are reported as timestamp-free events through a valid/ready FIFO, so the game logic can consume simultaneous and multi-key input without losing transitions. It sits between the BTN_X/BTN_Y pads and the player-action logic, and runs from the system clock.

---
 rtl/keypad_matrix_scanner.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/keypad_matrix_scanner.sv
// Row-scanned ROWSxCOLS keypad with per-key frame debouncing and a press/release
// event FIFO (valid/ready) plus a sticky drop indicator.
module keypad_matrix_scanner #(
    parameter  int ROWS       = 4,
    parameter  int COLS       = 5,
    parameter  int SCAN_DIV   = 16,
    parameter  int DEBOUNCE   = 4,
    parameter  int FIFO_DEPTH = 8,
    localparam int N          = ROWS * COLS,
    localparam int CODE_W     = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    output logic [ROWS-1:0]   row_n,
    input  logic [COLS-1:0]   col_n,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [CODE_W-1:0] evt_code,
    output logic              evt_press,
    output logic [N-1:0]      key_state,
    output logic              any_key,
    output logic              overflow,
    input  logic              ovf_clr
);

    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic {
        S_DRIVE  = 1'b0,
        S_COMMIT = 1'b1
    } state_t;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic              press;
    } evt_t;

    // ------------------------------------------------------------------
    // Column synchronizer; idle pulled-up columns read as all ones.
    logic [COLS-1:0] r_sync1, r_sync2;
    logic [COLS-1:0] w_col_act;

    // NOTE: sequential state always uses non-blocking (<=) so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= col_n;
            r_sync2 <= r_sync1;
        end
    end

    assign w_col_act = ~r_sync2;

    // ------------------------------------------------------------------
    // Scan FSM
    state_t            r_state, w_state_nxt;
    logic [ROW_W-1:0]  r_row, w_row_nxt;
    logic [DIV_W-1:0]  r_div, w_div_nxt;
    logic [CODE_W-1:0] r_key, w_key_nxt;
    logic [ROWS-1:0]   r_row_n, w_row_n_nxt;
    logic              r_run;
    logic              w_sample, w_commit;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_div_nxt   = r_div;
        w_key_nxt   = r_key;
        w_sample    = 1'b0;
        w_commit    = 1'b0;
        // The first cycle out of reset only loads row_n, so the FSM and the
        // registered row drive stay aligned from then on.
        if (r_run) begin
            case (r_state)
                S_DRIVE: begin
                    if (r_div == DIV_W'(SCAN_DIV - 1)) begin
                        w_sample  = 1'b1;
                        w_div_nxt = '0;
                        if (r_row == ROW_W'(ROWS - 1)) begin
                            w_row_nxt   = '0;
                            w_key_nxt   = '0;
                            w_state_nxt = S_COMMIT;
                        end else begin
                            w_row_nxt = r_row + ROW_W'(1);
                        end
                    end else begin
                        w_div_nxt = r_div + DIV_W'(1);
                    end
                end
                S_COMMIT: begin
                    w_commit = 1'b1;
                    if (r_key == CODE_W'(N - 1)) begin
                        w_key_nxt   = '0;
                        w_state_nxt = S_DRIVE;
                    end else begin
                        w_key_nxt = r_key + CODE_W'(1);
                    end
                end
                default: w_state_nxt = S_DRIVE;
            endcase
        end
        w_row_n_nxt = '1;
        if (w_state_nxt == S_DRIVE) w_row_n_nxt[w_row_nxt] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_DRIVE;
            r_row   <= '0;
            r_div   <= '0;
            r_key   <= '0;
            r_row_n <= '1;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_div   <= w_div_nxt;
            r_key   <= w_key_nxt;
            r_row_n <= w_row_n_nxt;
            r_run   <= 1'b1;
        end
    end

    assign row_n = r_row_n;

    // ------------------------------------------------------------------
    // Raw frame capture and per-key debounce
    logic [N-1:0]     r_raw;
    logic [N-1:0]     r_key_state;
    logic [CNT_W-1:0] r_cnt [N];
    logic             r_any_key;
    logic             w_raw_k, w_held_k, w_flip;
    logic [CNT_W:0]   w_cnt_inc;

    assign w_raw_k   = r_raw[r_key];
    assign w_held_k  = r_key_state[r_key];
    assign w_cnt_inc = {1'b0, r_cnt[r_key]} + (CNT_W + 1)'(1);
    assign w_flip    = w_commit && (w_raw_k != w_held_k) &&
                       (w_cnt_inc == (CNT_W + 1)'(DEBOUNCE));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_raw       <= '0;
            r_key_state <= '0;
            r_any_key   <= 1'b0;
            for (int i = 0; i < N; i++) r_cnt[i] <= '0;
        end else begin
            if (w_sample) r_raw[r_row*COLS +: COLS] <= w_col_act;
            if (w_commit) begin
                if (w_raw_k == w_held_k) begin
                    r_cnt[r_key] <= '0;
                end else if (w_flip) begin
                    r_key_state[r_key] <= w_raw_k;
                    r_cnt[r_key]       <= '0;
                end else begin
                    r_cnt[r_key] <= w_cnt_inc[CNT_W-1:0];
                end
            end
            r_any_key <= |r_key_state;
        end
    end

    assign key_state = r_key_state;
    assign any_key   = r_any_key;

    // ------------------------------------------------------------------
    // Event FIFO
    evt_t             r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_overflow;
    logic             w_valid, w_full, w_pop, w_push_ok, w_drop;
    evt_t             w_head;

    assign w_valid   = (r_count != '0);
    assign w_full    = (r_count == (PTR_W + 1)'(FIFO_DEPTH));
    assign w_pop     = w_valid && evt_ready;
    // When full, a same-cycle pop frees the slot being written.
    assign w_push_ok = w_flip && (!w_full || w_pop);
    assign w_drop    = w_flip && w_full && !w_pop;
    assign w_head    = r_mem[r_rd_ptr];

    // NOTE: FIFO storage is deliberately not reset; occupancy is tracked by
    // the reset pointers/count and the outputs are gated by evt_valid.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= '{code: r_key, press: w_raw_k};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push_ok && !w_pop)      r_count <= r_count + (PTR_W + 1)'(1);
            else if (!w_push_ok && w_pop) r_count <= r_count - (PTR_W + 1)'(1);
            if (w_drop)       r_overflow <= 1'b1;
            else if (ovf_clr) r_overflow <= 1'b0;
        end
    end

    assign evt_valid = w_valid;
    assign evt_code  = w_valid ? w_head.code  : '0;
    assign evt_press = w_valid ? w_head.press : 1'b0;
    assign overflow  = r_overflow;

endmodule
